// File: rtl/friscv_dpram_hs.sv
// Dual-port byte-enabled RAM with valid/ready handshake, zero-fill sweep after reset,
// configurable read latency, cross-port read-during-write mode and write/write collision tracking.
module friscv_dpram_hs #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0,
  parameter int INIT_SWEEP = 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    p1_valid,
  output logic                    p1_ready,
  input  logic                    p1_wren,
  input  logic [DATA_WIDTH/8-1:0] p1_wbe,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [DATA_WIDTH-1:0]   p1_data_in,
  output logic                    p1_rvalid,
  output logic [DATA_WIDTH-1:0]   p1_data_out,
  input  logic                    p2_valid,
  output logic                    p2_ready,
  input  logic                    p2_wren,
  input  logic [DATA_WIDTH/8-1:0] p2_wbe,
  input  logic [ADDR_WIDTH-1:0]   p2_addr,
  input  logic [DATA_WIDTH-1:0]   p2_data_in,
  output logic                    p2_rvalid,
  output logic [DATA_WIDTH-1:0]   p2_data_out,
  output logic                    init_done,
  output logic                    collision,
  output logic [15:0]             collision_cnt
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {S_RESET, S_INIT, S_RUN} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [ADDR_WIDTH-1:0]   r_sweep_addr;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic                    r_collision;
  logic [15:0]             r_collision_cnt;
  logic                    w_run;
  logic                    w_coll;

  logic                    w_valid  [0:1];
  logic                    w_wren   [0:1];
  logic [NB-1:0]           w_wbe    [0:1];
  logic [ADDR_WIDTH-1:0]   w_addr   [0:1];
  logic [DATA_WIDTH-1:0]   w_din    [0:1];
  logic                    w_wr_acc [0:1];
  logic                    w_rd_acc [0:1];
  logic                    w_rvalid [0:1];
  logic [DATA_WIDTH-1:0]   w_rdata  [0:1];

  function automatic logic [DATA_WIDTH-1:0] f_merge(input logic [DATA_WIDTH-1:0] old_w,
                                                    input logic [DATA_WIDTH-1:0] new_w,
                                                    input logic [NB-1:0]         be);
    logic [DATA_WIDTH-1:0] merged;
    merged = old_w;
    for (int b = 0; b < NB; b++)
      if (be[b]) merged[8*b +: 8] = new_w[8*b +: 8];
    return merged;
  endfunction

  assign w_valid[0] = p1_valid;   assign w_valid[1] = p2_valid;
  assign w_wren[0]  = p1_wren;    assign w_wren[1]  = p2_wren;
  assign w_wbe[0]   = p1_wbe;     assign w_wbe[1]   = p2_wbe;
  assign w_addr[0]  = p1_addr;    assign w_addr[1]  = p2_addr;
  assign w_din[0]   = p1_data_in; assign w_din[1]   = p2_data_in;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= S_RESET;
      r_sweep_addr <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_INIT) r_sweep_addr <= r_sweep_addr + 1'b1;
      else                   r_sweep_addr <= '0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RESET: w_state_next = (INIT_SWEEP != 0) ? S_INIT : S_RUN;
      S_INIT:  if (r_sweep_addr == {ADDR_WIDTH{1'b1}}) w_state_next = S_RUN;
      S_RUN:   w_state_next = S_RUN;
      default: w_state_next = S_RESET;
    endcase
  end

  assign w_run     = (r_state == S_RUN);
  assign init_done = w_run;
  assign p1_ready  = w_run;
  assign p2_ready  = w_run;

  // Port 2 lanes are written first so port 1 wins any byte both ports enable.
  always_ff @(posedge aclk) begin
    if (r_state == S_INIT) r_mem[r_sweep_addr] <= '0;
    for (int b = 0; b < NB; b++) begin
      if (w_wr_acc[1] && w_wbe[1][b]) r_mem[w_addr[1]][8*b +: 8] <= w_din[1][8*b +: 8];
      if (w_wr_acc[0] && w_wbe[0][b]) r_mem[w_addr[0]][8*b +: 8] <= w_din[0][8*b +: 8];
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic                  r_vld [RD_LATENCY];
    logic [DATA_WIDTH-1:0] r_dat [RD_LATENCY];
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_wr_acc[gi] = w_run && w_valid[gi] && w_wren[gi];
    assign w_rd_acc[gi] = w_run && w_valid[gi] && !w_wren[gi];

    // Write-first mode folds the other port's same-edge write bytes into the read word.
    always_comb begin
      w_rd_word = r_mem[w_addr[gi]];
      if (RDW_MODE == 1 && w_wr_acc[1-gi] && w_addr[1-gi] == w_addr[gi])
        w_rd_word = f_merge(r_mem[w_addr[gi]], w_din[1-gi], w_wbe[1-gi]);
    end

    // Data stages load only behind a valid, so the last stage holds the last read word.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        for (int k = 0; k < RD_LATENCY; k++) begin
          r_vld[k] <= 1'b0;
          r_dat[k] <= '0;
        end
      end else begin
        r_vld[0] <= w_rd_acc[gi];
        if (w_rd_acc[gi]) r_dat[0] <= w_rd_word;
        for (int k = 1; k < RD_LATENCY; k++) begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) r_dat[k] <= r_dat[k-1];
        end
      end
    end

    assign w_rvalid[gi] = r_vld[RD_LATENCY-1];
    assign w_rdata[gi]  = r_dat[RD_LATENCY-1];
  end

  assign p1_rvalid   = w_rvalid[0];
  assign p1_data_out = w_rdata[0];
  assign p2_rvalid   = w_rvalid[1];
  assign p2_data_out = w_rdata[1];

  assign w_coll = w_wr_acc[0] && w_wr_acc[1] && (w_addr[0] == w_addr[1]) && |(w_wbe[0] & w_wbe[1]);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_collision     <= 1'b0;
      r_collision_cnt <= '0;
    end else begin
      r_collision <= w_coll;
      if (w_coll && r_collision_cnt != 16'hFFFF) r_collision_cnt <= r_collision_cnt + 16'd1;
    end
  end

  assign collision     = r_collision;
  assign collision_cnt = r_collision_cnt;

endmodule

// File: tb/tb_friscv_dpram_hs.sv
// Directed bench: instance A (4-bit addr, latency 2, read-first, sweep) and
// instance B (4-bit addr, latency 3, write-first, no sweep).
module tb_friscv_dpram_hs;

  logic aclk;
  logic a_rstn, b_rstn;

  logic        a_valid [0:1], a_wren [0:1], a_ready [0:1], a_rvalid [0:1];
  logic [3:0]  a_wbe [0:1], a_addr [0:1];
  logic [31:0] a_din [0:1], a_dout [0:1];
  logic        a_init_done, a_coll;
  logic [15:0] a_ccnt;

  logic        b_valid [0:1], b_wren [0:1], b_ready [0:1], b_rvalid [0:1];
  logic [3:0]  b_wbe [0:1], b_addr [0:1];
  logic [31:0] b_din [0:1], b_dout [0:1];
  logic        b_init_done, b_coll;
  logic [15:0] b_ccnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  friscv_dpram_hs #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(2), .RDW_MODE(0), .INIT_SWEEP(1)) u_a (
    .aclk(aclk), .aresetn(a_rstn),
    .p1_valid(a_valid[0]), .p1_ready(a_ready[0]), .p1_wren(a_wren[0]), .p1_wbe(a_wbe[0]),
    .p1_addr(a_addr[0]), .p1_data_in(a_din[0]), .p1_rvalid(a_rvalid[0]), .p1_data_out(a_dout[0]),
    .p2_valid(a_valid[1]), .p2_ready(a_ready[1]), .p2_wren(a_wren[1]), .p2_wbe(a_wbe[1]),
    .p2_addr(a_addr[1]), .p2_data_in(a_din[1]), .p2_rvalid(a_rvalid[1]), .p2_data_out(a_dout[1]),
    .init_done(a_init_done), .collision(a_coll), .collision_cnt(a_ccnt)
  );

  friscv_dpram_hs #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(3), .RDW_MODE(1), .INIT_SWEEP(0)) u_b (
    .aclk(aclk), .aresetn(b_rstn),
    .p1_valid(b_valid[0]), .p1_ready(b_ready[0]), .p1_wren(b_wren[0]), .p1_wbe(b_wbe[0]),
    .p1_addr(b_addr[0]), .p1_data_in(b_din[0]), .p1_rvalid(b_rvalid[0]), .p1_data_out(b_dout[0]),
    .p2_valid(b_valid[1]), .p2_ready(b_ready[1]), .p2_wren(b_wren[1]), .p2_wbe(b_wbe[1]),
    .p2_addr(b_addr[1]), .p2_data_in(b_din[1]), .p2_rvalid(b_rvalid[1]), .p2_data_out(b_dout[1]),
    .init_done(b_init_done), .collision(b_coll), .collision_cnt(b_ccnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic a_req(input int p, input logic wr, input logic [3:0] wbe,
                       input logic [3:0] addr, input logic [31:0] d);
    a_valid[p] = 1'b1; a_wren[p] = wr; a_wbe[p] = wbe; a_addr[p] = addr; a_din[p] = d;
  endtask

  task automatic b_req(input int p, input logic wr, input logic [3:0] wbe,
                       input logic [3:0] addr, input logic [31:0] d);
    b_valid[p] = 1'b1; b_wren[p] = wr; b_wbe[p] = wbe; b_addr[p] = addr; b_din[p] = d;
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      a_valid[p] = 1'b0; a_wren[p] = 1'b0;
      b_valid[p] = 1'b0; b_wren[p] = 1'b0;
    end
  endtask

  // Latency-2 read on A: low one cycle, high one cycle, then low with data held.
  task automatic a_rd(input int p, input logic [3:0] addr, input logic [31:0] exp, input string tag);
    a_req(p, 1'b0, 4'h0, addr, 32'h0);
    @(negedge aclk); idle();
    check({tag, "_rv_early"}, 32'(a_rvalid[p]), 32'd0);
    @(negedge aclk);
    check({tag, "_rv"}, 32'(a_rvalid[p]), 32'd1);
    check(tag, a_dout[p], exp);
    @(negedge aclk);
    check({tag, "_rv_drop"}, 32'(a_rvalid[p]), 32'd0);
    check({tag, "_hold"}, a_dout[p], exp);
  endtask

  initial begin
    a_rstn = 1'b0; b_rstn = 1'b0;
    for (int p = 0; p < 2; p++) begin
      a_wbe[p] = '0; a_addr[p] = '0; a_din[p] = '0;
      b_wbe[p] = '0; b_addr[p] = '0; b_din[p] = '0;
    end
    idle();
    repeat (2) @(negedge aclk);

    check("rst_ready1", 32'(a_ready[0]), 32'd0);
    check("rst_ready2", 32'(a_ready[1]), 32'd0);
    check("rst_init_done", 32'(a_init_done), 32'd0);
    check("rst_rvalid", 32'(a_rvalid[0]), 32'd0);
    check("rst_dout", a_dout[1], 32'd0);
    check("rst_coll", 32'(a_coll), 32'd0);
    check("rst_ccnt", 32'(a_ccnt), 32'd0);
    check("rst_b_ready", 32'(b_ready[0]), 32'd0);

    a_rstn = 1'b1; b_rstn = 1'b1;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk);
      if (i == 0) begin
        check("b_nosweep_done", 32'(b_init_done), 32'd1);
        check("b_nosweep_ready", 32'(b_ready[1]), 32'd1);
      end
      if (a_init_done) break;
      cyc++;
    end
    check("a_sweep_cycles", cyc, 32'd16);
    check("a_ready_run", 32'(a_ready[0]), 32'd1);

    // Byte-enable write then cross-port read
    a_req(0, 1'b1, 4'b0101, 4'd3, 32'hAABBCCDD);
    @(negedge aclk); idle();
    a_rd(1, 4'd3, 32'h00BB00DD, "wbe_rd");

    // Write/write collision on addr 7
    a_req(0, 1'b1, 4'b0011, 4'd7, 32'h11111111);
    a_req(1, 1'b1, 4'b0110, 4'd7, 32'h22222222);
    @(negedge aclk); idle();
    check("coll_pulse", 32'(a_coll), 32'd1);
    check("coll_cnt", 32'(a_ccnt), 32'd1);
    @(negedge aclk);
    check("coll_drop", 32'(a_coll), 32'd0);
    a_rd(0, 4'd7, 32'h00221111, "coll_rd");

    // Same address, disjoint lanes: no collision
    a_req(0, 1'b1, 4'b1000, 4'd7, 32'h33000000);
    a_req(1, 1'b1, 4'b0001, 4'd7, 32'h00000044);
    @(negedge aclk); idle();
    check("nocoll_pulse", 32'(a_coll), 32'd0);
    check("nocoll_cnt", 32'(a_ccnt), 32'd1);
    a_rd(1, 4'd7, 32'h33221144, "nocoll_rd");

    // Read-first read-during-write
    a_req(0, 1'b1, 4'hF, 4'd5, 32'h00000001);
    @(negedge aclk); idle();
    a_req(0, 1'b1, 4'hF, 4'd5, 32'h00000002);
    a_req(1, 1'b0, 4'h0, 4'd5, 32'h0);
    @(negedge aclk); idle();
    check("rdw0_early", 32'(a_rvalid[1]), 32'd0);
    @(negedge aclk);
    check("rdw0_rv", 32'(a_rvalid[1]), 32'd1);
    check("rdw0_data", a_dout[1], 32'h00000001);
    @(negedge aclk);
    a_rd(0, 4'd5, 32'h00000002, "rdw0_after");

    // Both ports read one address
    a_req(0, 1'b0, 4'h0, 4'd3, 32'h0);
    a_req(1, 1'b0, 4'h0, 4'd3, 32'h0);
    @(negedge aclk); idle();
    @(negedge aclk);
    check("dual_rv1", 32'(a_rvalid[0]), 32'd1);
    check("dual_rv2", 32'(a_rvalid[1]), 32'd1);
    check("dual_d1", a_dout[0], 32'h00BB00DD);
    check("dual_d2", a_dout[1], 32'h00BB00DD);
    @(negedge aclk);

    // Zero byte-enable write changes nothing and yields no rvalid
    a_req(0, 1'b1, 4'b0000, 4'd3, 32'hFFFFFFFF);
    @(negedge aclk); idle();
    check("wbe0_norv", 32'(a_rvalid[0]), 32'd0);
    @(negedge aclk);
    check("wbe0_norv2", 32'(a_rvalid[0]), 32'd0);
    a_rd(0, 4'd3, 32'h00BB00DD, "wbe0_rd");

    // Reset one cycle after a read accept
    a_req(1, 1'b1, 4'hF, 4'd9, 32'hDEADBEEF);
    @(negedge aclk); idle();
    a_req(0, 1'b0, 4'h0, 4'd9, 32'h0);
    @(negedge aclk); idle();
    a_rstn = 1'b0;
    #1;
    check("mid_rst_rv", 32'(a_rvalid[0]), 32'd0);
    check("mid_rst_dout", a_dout[0], 32'd0);
    check("mid_rst_ready", 32'(a_ready[0]), 32'd0);
    check("mid_rst_done", 32'(a_init_done), 32'd0);
    check("mid_rst_ccnt", 32'(a_ccnt), 32'd0);
    @(negedge aclk);
    check("mid_rst_rv2", 32'(a_rvalid[0]), 32'd0);
    check("mid_rst_dout2", a_dout[0], 32'd0);
    @(negedge aclk);
    a_rstn = 1'b1;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk);
      check("resweep_norv", 32'(a_rvalid[0]), 32'd0);
      if (a_init_done) break;
      cyc++;
    end
    check("a_resweep_cycles", cyc, 32'd16);

    // Pipelined readback of every address after the sweep
    for (int i = 0; i < 18; i++) begin
      if (i >= 2) begin
        check("sweep_rv", 32'(a_rvalid[0]), 32'd1);
        check("sweep_rd", a_dout[0], 32'd0);
      end
      if (i < 16) a_req(0, 1'b0, 4'h0, 4'(i), 32'h0);
      else idle();
      @(negedge aclk);
    end

    // Instance B: write-first read-during-write
    b_req(0, 1'b1, 4'hF, 4'd5, 32'h00000001);
    @(negedge aclk); idle();
    b_req(0, 1'b1, 4'hF, 4'd5, 32'h00000002);
    b_req(1, 1'b0, 4'h0, 4'd5, 32'h0);
    @(negedge aclk); idle();
    check("rdw1_early1", 32'(b_rvalid[1]), 32'd0);
    @(negedge aclk);
    check("rdw1_early2", 32'(b_rvalid[1]), 32'd0);
    @(negedge aclk);
    check("rdw1_rv", 32'(b_rvalid[1]), 32'd1);
    check("rdw1_data", b_dout[1], 32'h00000002);
    @(negedge aclk);

    // Instance B: back-to-back reads with latency 3
    for (int i = 0; i < 3; i++) begin
      b_req(1, 1'b1, 4'hF, 4'(i), 32'hA0 + 32'(i));
      @(negedge aclk);
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      b_req(0, 1'b0, 4'h0, 4'(i), 32'h0);
      @(negedge aclk);
      if (i < 2) check("b2b_early", 32'(b_rvalid[0]), 32'd0);
      else begin
        check("b2b_rv0", 32'(b_rvalid[0]), 32'd1);
        check("b2b_d0", b_dout[0], 32'hA0);
      end
    end
    idle();
    @(negedge aclk);
    check("b2b_rv1", 32'(b_rvalid[0]), 32'd1);
    check("b2b_d1", b_dout[0], 32'hA1);
    @(negedge aclk);
    check("b2b_rv2", 32'(b_rvalid[0]), 32'd1);
    check("b2b_d2", b_dout[0], 32'hA2);
    @(negedge aclk);
    check("b2b_drop", 32'(b_rvalid[0]), 32'd0);
    check("b2b_hold", b_dout[0], 32'hA2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
